// File: rtl/ycfsm_sync_row.sv
// Clocked N-channel Morphle match row: each channel joins a dual-rail input token with a
// dual-rail match token and holds the registered result until both sides return to empty.
module ycfsm_sync_row #(
    parameter int N    = 8,
    parameter bit MODE = 1'b0
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic [2*N-1:0] in,
    input  logic [2*N-1:0] match,
    output logic [2*N-1:0] out,
    output logic           done,
    output logic           empty,
    output logic [N-1:0]   err,
    output logic [2*N-1:0] state_dbg
);

    localparam logic [1:0] VE = 2'b00;
    localparam logic [1:0] V0 = 2'b01;
    localparam logic [1:0] V1 = 2'b10;
    localparam logic [1:0] VX = 2'b11;

    typedef enum logic [1:0] {
        S_DISARMED = 2'd0,
        S_IDLE     = 2'd1,
        S_PARTIAL  = 2'd2,
        S_FIRED    = 2'd3
    } state_t;

    state_t         st     [N];
    state_t         st_n   [N];
    logic [1:0]     lin    [N];
    logic [1:0]     lin_n  [N];
    logic [1:0]     lmatch [N];
    logic [1:0]     lmatch_n [N];
    logic [2*N-1:0] out_n;
    logic [N-1:0]   err_n;
    logic           done_n;
    logic           empty_n;

    function automatic logic [1:0] fire(input logic [1:0] a, input logic [1:0] b);
        if (MODE == 1'b0) return (a == V1 && b == V1) ? V1 : V0;
        else              return (a == b) ? V1 : V0;
    endfunction

    // A held token may only go back to empty; a direct V0<->V1 flip is a protocol error.
    function automatic logic conflict(input logic [1:0] held, input logic [1:0] seen);
        return (held != VE) && (seen != VE) && (seen != held);
    endfunction

    // Token protocol: a side is present while its pair is V0/V1 and absent at empty; a token
    // is consumed when latched and the channel re-opens only after both sides go empty.
    always_comb begin
        out_n   = out;
        err_n   = err;
        done_n  = 1'b1;
        empty_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            st_n[i]     = st[i];
            lin_n[i]    = lin[i];
            lmatch_n[i] = lmatch[i];
            if (st[i] == S_DISARMED) begin
                if (in[2*i +: 2] == VE && match[2*i +: 2] == VE) st_n[i] = S_IDLE;
            end else if (in[2*i +: 2] == VX || match[2*i +: 2] == VX ||
                         conflict(lin[i], in[2*i +: 2]) ||
                         conflict(lmatch[i], match[2*i +: 2])) begin
                err_n[i] = 1'b1;
            end else begin
                case (st[i])
                    S_IDLE: begin
                        lin_n[i]    = in[2*i +: 2];
                        lmatch_n[i] = match[2*i +: 2];
                        if (in[2*i +: 2] != VE && match[2*i +: 2] != VE) begin
                            st_n[i]        = S_FIRED;
                            out_n[2*i +: 2] = fire(in[2*i +: 2], match[2*i +: 2]);
                        end else if (in[2*i +: 2] != VE || match[2*i +: 2] != VE) begin
                            st_n[i] = S_PARTIAL;
                        end
                    end
                    S_PARTIAL: begin
                        if ((lin[i] != VE && in[2*i +: 2] == VE) ||
                            (lmatch[i] != VE && match[2*i +: 2] == VE)) begin
                            lin_n[i]    = VE;
                            lmatch_n[i] = VE;
                            st_n[i]     = S_IDLE;
                        end else if (lin[i] == VE && in[2*i +: 2] != VE) begin
                            lin_n[i]        = in[2*i +: 2];
                            st_n[i]         = S_FIRED;
                            out_n[2*i +: 2] = fire(in[2*i +: 2], lmatch[i]);
                        end else if (lmatch[i] == VE && match[2*i +: 2] != VE) begin
                            lmatch_n[i]     = match[2*i +: 2];
                            st_n[i]         = S_FIRED;
                            out_n[2*i +: 2] = fire(lin[i], match[2*i +: 2]);
                        end
                    end
                    S_FIRED: begin
                        if (in[2*i +: 2] == VE && match[2*i +: 2] == VE) begin
                            lin_n[i]        = VE;
                            lmatch_n[i]     = VE;
                            st_n[i]         = S_IDLE;
                            out_n[2*i +: 2] = VE;
                        end
                    end
                    default: ;
                endcase
            end
            done_n  = done_n & (st_n[i] == S_FIRED);
            empty_n = empty_n & (st_n[i] == S_IDLE || st_n[i] == S_DISARMED);
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int i = 0; i < N; i++) begin
                st[i]     <= S_DISARMED;
                lin[i]    <= VE;
                lmatch[i] <= VE;
            end
            out   <= '0;
            err   <= '0;
            done  <= 1'b0;
            empty <= 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                st[i]     <= st_n[i];
                lin[i]    <= lin_n[i];
                lmatch[i] <= lmatch_n[i];
            end
            out   <= out_n;
            err   <= err_n;
            done  <= done_n;
            empty <= empty_n;
        end
    end

    always_comb begin
        state_dbg = '0;
        for (int i = 0; i < N; i++) state_dbg[2*i +: 2] = st[i];
    end

endmodule

// File: tb/tb_ycfsm_sync_row.sv
// Bench for ycfsm_sync_row: directed protocol scenarios followed by random token traffic,
// with both match modes checked every cycle against a token-level reference model.
module tb_ycfsm_sync_row;

    localparam int N = 8;
    localparam logic [1:0] VE = 2'b00;
    localparam logic [1:0] V0 = 2'b01;
    localparam logic [1:0] V1 = 2'b10;
    localparam logic [1:0] VX = 2'b11;

    logic           clk = 1'b0;
    logic           nreset;
    logic [2*N-1:0] in, match;
    logic [2*N-1:0] out0, out1, dbg0, dbg1;
    logic           done0, done1, empty0, empty1;
    logic [N-1:0]   err0, err1;

    // stimulus staged by the sequence, applied by cyc()
    logic [2*N-1:0] tin, tmat;
    logic           trst;

    // reference model: per channel an armed flag and two optional tokens (-1 = none, 0/1)
    bit m_armed [N];
    int m_a     [N];
    int m_b     [N];
    bit m_err   [N];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ycfsm_sync_row #(.N(N), .MODE(1'b0)) u_and (
        .clk(clk), .nreset(nreset), .in(in), .match(match), .out(out0),
        .done(done0), .empty(empty0), .err(err0), .state_dbg(dbg0)
    );

    ycfsm_sync_row #(.N(N), .MODE(1'b1)) u_eq (
        .clk(clk), .nreset(nreset), .in(in), .match(match), .out(out1),
        .done(done1), .empty(empty1), .err(err1), .state_dbg(dbg1)
    );

    function automatic int dec(input logic [1:0] t);
        case (t)
            2'b00:   return -1;
            2'b01:   return 0;
            2'b10:   return 1;
            default: return 2;
        endcase
    endfunction

    task automatic model_step();
        int ti, tm;
        if (!trst) begin
            for (int i = 0; i < N; i++) begin
                m_armed[i] = 0; m_a[i] = -1; m_b[i] = -1; m_err[i] = 0;
            end
            return;
        end
        for (int i = 0; i < N; i++) begin
            ti = dec(tin[2*i +: 2]);
            tm = dec(tmat[2*i +: 2]);
            if (!m_armed[i]) begin
                if (ti < 0 && tm < 0) m_armed[i] = 1;
            end else if (ti == 2 || tm == 2 ||
                         (m_a[i] >= 0 && ti >= 0 && ti != m_a[i]) ||
                         (m_b[i] >= 0 && tm >= 0 && tm != m_b[i])) begin
                m_err[i] = 1;
            end else if (m_a[i] >= 0 && m_b[i] >= 0) begin
                if (ti < 0 && tm < 0) begin m_a[i] = -1; m_b[i] = -1; end
            end else if (m_a[i] >= 0) begin
                if (ti < 0) m_a[i] = -1;
                else if (tm >= 0) m_b[i] = tm;
            end else if (m_b[i] >= 0) begin
                if (tm < 0) m_b[i] = -1;
                else if (ti >= 0) m_a[i] = ti;
            end else begin
                m_a[i] = ti;
                m_b[i] = tm;
            end
        end
    endtask

    function automatic logic [2*N-1:0] exp_out(input bit eq_mode);
        logic [2*N-1:0] r;
        bit v;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (m_a[i] >= 0 && m_b[i] >= 0) begin
                v = eq_mode ? (m_a[i] == m_b[i]) : (m_a[i] == 1 && m_b[i] == 1);
                r[2*i +: 2] = v ? V1 : V0;
            end
        end
        return r;
    endfunction

    function automatic logic exp_done();
        for (int i = 0; i < N; i++) if (!(m_a[i] >= 0 && m_b[i] >= 0)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_empty();
        for (int i = 0; i < N; i++) if (m_a[i] >= 0 || m_b[i] >= 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [N-1:0] exp_err();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_err[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        in     = tin;
        match  = tmat;
        nreset = trst;
        @(posedge clk);
        model_step();
        #1;
        chk("out_and",   32'(out0),   32'(exp_out(1'b0)));
        chk("out_eq",    32'(out1),   32'(exp_out(1'b1)));
        chk("done_and",  32'(done0),  32'(exp_done()));
        chk("done_eq",   32'(done1),  32'(exp_done()));
        chk("empty_and", 32'(empty0), 32'(exp_empty()));
        chk("empty_eq",  32'(empty1), 32'(exp_empty()));
        chk("err_and",   32'(err0),   32'(exp_err()));
        chk("err_eq",    32'(err1),   32'(exp_err()));
    endtask

    task automatic set_in(input int ch, input logic [1:0] v);
        tin[2*ch +: 2] = v;
    endtask

    task automatic set_match(input int ch, input logic [1:0] v);
        tmat[2*ch +: 2] = v;
    endtask

    task automatic clear_all();
        tin  = '0;
        tmat = '0;
    endtask

    function automatic logic [1:0] next_lane(input logic [1:0] cur);
        int r;
        if ($urandom_range(0, 2) != 0) return cur;
        r = $urandom_range(0, 99);
        if (cur != VE) begin
            if (r < 80) return VE;
            if (r < 99) return (cur == V0) ? V1 : V0;
            return VX;
        end
        if (r < 30) return VE;
        if (r < 64) return V0;
        if (r < 99) return V1;
        return VX;
    endfunction

    initial begin
        in = '0; match = '0; nreset = 1'b0;
        clear_all();
        trst = 1'b0;

        // reset state
        cyc();
        cyc();
        chk("rst_out",   32'(out0),   32'h0);
        chk("rst_done",  32'(done0),  32'h0);
        chk("rst_empty", 32'(empty0), 32'h1);
        chk("rst_err",   32'(err0),   32'h0);
        trst = 1'b1;
        cyc();

        // ch0: in then match, result one cycle after the later token, then release
        set_in(0, V1);    cyc();
        chk("t1_partial", 32'(out0[1:0]), 32'(VE));
        chk("t1_empty",   32'(empty0),    32'h0);
        set_match(0, V1); cyc();
        chk("t1_fire", 32'(out0[1:0]), 32'(V1));
        clear_all();      cyc();
        chk("t1_release", 32'(out0[1:0]), 32'(VE));

        // mode truth tables with simultaneous arrival
        set_in(0, V0); set_match(0, V1); cyc();
        chk("t2_and_01", 32'(out0[1:0]), 32'(V0));
        chk("t2_eq_01",  32'(out1[1:0]), 32'(V0));
        clear_all(); cyc();
        set_in(0, V1); set_match(0, V0); cyc();
        chk("t2_and_10", 32'(out0[1:0]), 32'(V0));
        clear_all(); cyc();
        set_in(0, V0); set_match(0, V0); cyc();
        chk("t2_and_00", 32'(out0[1:0]), 32'(V0));
        chk("t2_eq_00",  32'(out1[1:0]), 32'(V1));
        clear_all(); cyc();

        // reset while ch2 is fired with tokens still held
        set_in(2, V1); set_match(2, V1); cyc();
        chk("t3_fired", 32'(out0[5:4]), 32'(V1));
        trst = 1'b0; cyc();
        trst = 1'b1; cyc();
        chk("t3_after_rst", 32'(out0[5:4]), 32'(VE));
        cyc();
        chk("t3_held", 32'(out0[5:4]), 32'(VE));
        clear_all(); cyc();
        set_in(2, V1); set_match(2, V1); cyc();
        chk("t3_refire", 32'(out0[5:4]), 32'(V1));
        clear_all(); cyc();

        // protocol errors: illegal code and a flipped latched token
        set_in(1, VX); cyc();
        chk("t4_illegal", 32'(err0[1]), 32'h1);
        chk("t4_out1",    32'(out0[3:2]), 32'(VE));
        set_in(1, VE); cyc();
        chk("t4_sticky", 32'(err0[1]), 32'h1);
        set_in(3, V0); cyc();
        set_match(3, V0); cyc();
        set_in(3, V1); cyc();
        chk("t4_flip",     32'(err0[3]), 32'h1);
        chk("t4_flip_out", 32'(out0[7:6]), 32'(V0));
        clear_all(); cyc();

        // all channels fire one per cycle; done only once the last one fires
        trst = 1'b0; cyc();
        trst = 1'b1; cyc();
        for (int k = 0; k < N; k++) begin
            set_in(k, V1); set_match(k, V1); cyc();
            chk("t5_empty", 32'(empty0), 32'h0);
            chk("t5_done",  32'(done0),  (k == N - 1) ? 32'h1 : 32'h0);
        end
        clear_all(); cyc();
        chk("t5_done_drop", 32'(done0), 32'h0);

        // withdraw before match arrives, then match alone
        set_in(4, V1); cyc();
        set_in(4, VE); cyc();
        chk("t6_withdraw_out",   32'(out0[9:8]), 32'(VE));
        chk("t6_withdraw_empty", 32'(empty0),    32'h1);
        set_match(4, V1); cyc();
        chk("t6_partial_out",   32'(out0[9:8]), 32'(VE));
        chk("t6_partial_empty", 32'(empty0),    32'h0);
        clear_all(); cyc();

        // random token traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            trst = ($urandom_range(0, 79) != 0);
            for (int i = 0; i < N; i++) begin
                set_in(i, next_lane(tin[2*i +: 2]));
                set_match(i, next_lane(tmat[2*i +: 2]));
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
